// File: rtl/seq_checker_3_pkg.sv
// Shared types for the modulo-3 sequence checker: FSM state encoding,
// fault cause codes and the modulo-3 successor helper.
package seq_chk_pkg;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_STEP    = 2'b10;
  localparam logic [1:0] ERR_HOLD    = 2'b11;

  function automatic logic [1:0] mod3_next(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

endpackage

// File: rtl/seq_checker_3_if.sv
// Observation bus between the counter side (master) and the sequence
// checker (slave): counter state and clear in, status out.
interface seq_checker_3_if #(
  parameter int WRAP_W = 8
);
  logic [1:0]        q;
  logic              clr;
  logic              locked;
  logic              err;
  logic [1:0]        err_code;
  logic [WRAP_W-1:0] wraps;

  modport master (
    output q, clr,
    input  locked, err, err_code, wraps
  );

  modport slave (
    input  q, clr,
    output locked, err, err_code, wraps
  );
endinterface

// File: rtl/seq_checker_3_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_checker_3.sv
// Checks the 0->1->2->0 sequence of a modulo-3 counter, locks after LOCK_CNT
// legal steps, counts wraps and latches the first fault.
// Optional macro SEQ_CHECKER_HOLD_EN: a hold while locked is accepted.
module seq_checker_3
  import seq_chk_pkg::*;
#(
  parameter int WRAP_W   = 8,
  parameter int LOCK_CNT = 3
) (
  input  logic           clk,
  input  logic           reset,
  seq_checker_3_if.slave bus
);

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  state_t     state_reg;
  logic [3:0] run_reg;
  logic [1:0] prev_q_reg;
  logic       prev_valid_reg;
  logic       locked_reg;
  logic       err_reg;
  logic [1:0] err_code_reg;

  logic       legal;
  logic       hold;
  logic       wrap_inc;
  logic [3:0] run_inc;

  // A step is only judged once a previous sample exists and was itself legal.
  assign legal    = prev_valid_reg && (prev_q_reg != 2'd3) && (bus.q == mod3_next(prev_q_reg));
  assign hold     = prev_valid_reg && (bus.q == prev_q_reg);
  assign wrap_inc = (state_reg == ST_LOCKED) && legal && (prev_q_reg == 2'd2) && !bus.clr;
  assign run_inc  = run_reg + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_SYNC;
      run_reg        <= 4'd0;
      prev_q_reg     <= 2'd0;
      prev_valid_reg <= 1'b0;
      locked_reg     <= 1'b0;
      err_reg        <= 1'b0;
      err_code_reg   <= ERR_NONE;
    end else begin
      prev_q_reg <= bus.q;
      if (bus.clr) begin
        state_reg      <= ST_SYNC;
        run_reg        <= 4'd0;
        prev_valid_reg <= 1'b0;
        locked_reg     <= 1'b0;
        err_reg        <= 1'b0;
        err_code_reg   <= ERR_NONE;
      end else begin
        prev_valid_reg <= 1'b1;
        case (state_reg)
          ST_SYNC: begin
            if (legal) begin
              run_reg <= run_inc;
              if (run_inc == LOCK_TGT) begin
                state_reg  <= ST_LOCKED;
                locked_reg <= 1'b1;
              end
            end else begin
              run_reg <= 4'd0;
            end
          end
          ST_LOCKED: begin
            if (bus.q == 2'd3) begin
              state_reg    <= ST_FAULT;
              locked_reg   <= 1'b0;
              err_reg      <= 1'b1;
              err_code_reg <= ERR_ILLEGAL;
            end else if (legal) begin
              state_reg <= ST_LOCKED;
            end else if (hold) begin
`ifdef SEQ_CHECKER_HOLD_EN
              state_reg <= ST_LOCKED;
`else
              state_reg    <= ST_FAULT;
              locked_reg   <= 1'b0;
              err_reg      <= 1'b1;
              err_code_reg <= ERR_HOLD;
`endif
            end else begin
              state_reg    <= ST_FAULT;
              locked_reg   <= 1'b0;
              err_reg      <= 1'b1;
              err_code_reg <= ERR_STEP;
            end
          end
          ST_FAULT: state_reg <= ST_FAULT;
          default: begin
            state_reg  <= ST_SYNC;
            run_reg    <= 4'd0;
            locked_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .W(WRAP_W)
  ) u_wraps (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clr),
    .inc   (wrap_inc),
    .count (bus.wraps)
  );

  assign bus.locked   = locked_reg;
  assign bus.err      = err_reg;
  assign bus.err_code = err_code_reg;

endmodule

// File: tb/tb_seq_checker_3.sv
// Directed, table-driven bench for seq_checker_3; a second WRAP_W=2 instance
// shadows the main one to show wrap saturation.
module tb_seq_checker_3;

  typedef struct {
    logic [1:0] q;
    logic       clr;
    logic       locked;
    logic       err;
    logic [1:0] code;
    logic [7:0] wraps;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vq[$];
  int   split_at;

  seq_checker_3_if #(.WRAP_W(8)) bus ();
  seq_checker_3_if #(.WRAP_W(2)) bus2 ();

  assign bus2.q   = bus.q;
  assign bus2.clr = bus.clr;

  seq_checker_3 #(.WRAP_W(8), .LOCK_CNT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  seq_checker_3 #(.WRAP_W(2), .LOCK_CNT(3)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] q, input logic clr, input logic l, input logic e,
                     input logic [1:0] c, input logic [7:0] w);
    vec_t v;
    v.q = q; v.clr = clr; v.locked = l; v.err = e; v.code = c; v.wraps = w;
    vq.push_back(v);
  endtask

  task automatic run_vec(input int i);
    logic [7:0] w_sat;
    bus.q   = vq[i].q;
    bus.clr = vq[i].clr;
    @(posedge clk);
    #1;
    w_sat = (vq[i].wraps > 8'd3) ? 8'd3 : vq[i].wraps;
    $display("vec %0d q=%0d clr=%0b -> locked=%0b err=%0b code=%0d wraps=%0d wraps_sat=%0d",
             i, vq[i].q, vq[i].clr, bus.locked, bus.err, bus.err_code, bus.wraps, bus2.wraps);
    chk("locked", i, {7'd0, bus.locked}, {7'd0, vq[i].locked});
    chk("err", i, {7'd0, bus.err}, {7'd0, vq[i].err});
    chk("err_code", i, {6'd0, bus.err_code}, {6'd0, vq[i].code});
    chk("wraps", i, bus.wraps, vq[i].wraps);
    chk("wraps_sat", i, {6'd0, bus2.wraps}, w_sat);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    bus.q   = 2'd0;
    bus.clr = 1'b0;

    // Lock on 0,1,2,0 then one counted wrap
    add(0,0, 0,0,0,0); add(1,0, 0,0,0,0); add(2,0, 0,0,0,0); add(0,0, 1,0,0,0);
    add(1,0, 1,0,0,0); add(2,0, 1,0,0,0); add(0,0, 1,0,0,1);
    // Skip 0->2 faults; later legal steps are ignored
    add(2,0, 0,1,2,1);
    add(0,0, 0,1,2,1); add(1,0, 0,1,2,1); add(2,0, 0,1,2,1);
    add(0,0, 0,1,2,1); add(1,0, 0,1,2,1); add(2,0, 0,1,2,1);
    // Clear, then capture plus three legal steps to relock
    add(0,1, 0,0,0,0); add(1,0, 0,0,0,0); add(2,0, 0,0,0,0); add(0,0, 0,0,0,0);
    add(1,0, 1,0,0,0);
    // In SYNC an illegal value only restarts the run
    add(0,1, 0,0,0,0); add(0,0, 0,0,0,0); add(1,0, 0,0,0,0); add(3,0, 0,0,0,0);
    add(0,0, 0,0,0,0); add(1,0, 0,0,0,0); add(2,0, 0,0,0,0); add(0,0, 1,0,0,0);
    // Five wraps while locked
    for (int k = 1; k <= 5; k++) begin
      add(1,0, 1,0,0,8'(k-1)); add(2,0, 1,0,0,8'(k-1)); add(0,0, 1,0,0,8'(k));
    end
    split_at = vq.size();
    // After async reset: relock, then hold q=1 for two cycles
    add(0,0, 0,0,0,0); add(1,0, 0,0,0,0); add(2,0, 0,0,0,0); add(0,0, 1,0,0,0);
    add(1,0, 1,0,0,0);
`ifdef SEQ_CHECKER_HOLD_EN
    add(1,0, 1,0,0,0); add(1,0, 1,0,0,0); add(2,0, 1,0,0,0); add(0,0, 1,0,0,1);
`else
    add(1,0, 0,1,3,0); add(1,0, 0,1,3,0); add(2,0, 0,1,3,0); add(0,0, 0,1,3,0);
`endif
    // Clear, relock, then q==3 while locked
    add(0,1, 0,0,0,0); add(0,0, 0,0,0,0); add(1,0, 0,0,0,0); add(2,0, 0,0,0,0);
    add(0,0, 1,0,0,0); add(3,0, 0,1,1,0); add(0,0, 0,1,1,0);

    #12;
    $display("reset held: locked=%0b err=%0b code=%0d wraps=%0d", bus.locked, bus.err, bus.err_code, bus.wraps);
    chk("reset_locked", -1, {7'd0, bus.locked}, 8'd0);
    chk("reset_err", -1, {7'd0, bus.err}, 8'd0);
    chk("reset_code", -1, {6'd0, bus.err_code}, 8'd0);
    chk("reset_wraps", -1, bus.wraps, 8'd0);
    reset = 1'b1;

    for (int i = 0; i < split_at; i++) run_vec(i);

    // Mid-cycle asynchronous reset while locked with five wraps
    #3;
    $display("pre-reset: locked=%0b wraps=%0d wraps_sat=%0d", bus.locked, bus.wraps, bus2.wraps);
    chk("pre_rst_locked", -2, {7'd0, bus.locked}, 8'd1);
    chk("pre_rst_wraps", -2, bus.wraps, 8'd5);
    chk("pre_rst_wraps_sat", -2, {6'd0, bus2.wraps}, 8'd3);
    reset = 1'b0;
    #1;
    $display("async reset: locked=%0b err=%0b code=%0d wraps=%0d wraps_sat=%0d",
             bus.locked, bus.err, bus.err_code, bus.wraps, bus2.wraps);
    chk("arst_locked", -3, {7'd0, bus.locked}, 8'd0);
    chk("arst_err", -3, {7'd0, bus.err}, 8'd0);
    chk("arst_code", -3, {6'd0, bus.err_code}, 8'd0);
    chk("arst_wraps", -3, bus.wraps, 8'd0);
    chk("arst_wraps_sat", -3, {6'd0, bus2.wraps}, 8'd0);
    #2;
    reset = 1'b1;

    for (int i = split_at; i < vq.size(); i++) run_vec(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
